// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage with ALU, branch target and iterative mul/div, registered into EX/MEM
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid               ID/EX holds a real instruction
//   in_EX[4:0]             [0] RegDst, [1] ALUSrc, [4:2] ALUOp
//   in_add                 PC+4
//   in_Dato1, in_Dato2     rs / rt operands (rt is also store data)
//   in_Extend              sign-extended immediate; [5:0] funct, [10:6] shamt
//   in_b20_16, in_b15_11   rt / rd register fields
//   ou_stall               combinational hold request for PC, IF/ID and ID/EX
//   ou_valid .. ou_wreg    EX/MEM boundary registers
module ex_stage #(
    parameter int MD_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [4:0]  in_EX,
    input  logic [31:0] in_add,
    input  logic [31:0] in_Dato1,
    input  logic [31:0] in_Dato2,
    input  logic [31:0] in_Extend,
    input  logic [4:0]  in_b20_16,
    input  logic [4:0]  in_b15_11,
    output logic        ou_stall,
    output logic        ou_valid,
    output logic [31:0] ou_alu,
    output logic        ou_zero,
    output logic [31:0] ou_branch_add,
    output logic [31:0] ou_Dato_2,
    output logic [4:0]  ou_wreg
);

    localparam int CNT_W = $clog2(MD_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

    md_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Working registers: mhi/mlo form the 64-bit product or {remainder, quotient}.
    logic [31:0] mhi_q, mhi_d, mlo_q, mlo_d, mb_q, mb_d, a_q, a_d;
    logic        div_q, div_d, negq_q, negq_d, negr_q, negr_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic [2:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] op_b;
    logic [4:0]  dest;
    logic        is_md;
    logic [31:0] alu_res;
    logic        wr_en;

    assign alu_op = in_EX[4:2];
    assign funct  = in_Extend[5:0];
    assign op_b   = in_EX[1] ? in_Extend : in_Dato2;
    assign dest   = in_EX[0] ? in_b15_11 : in_b20_16;
    assign is_md  = (alu_op == 3'b010) && (funct[5:2] == 4'b0110);

    // funct[0]=1 selects the unsigned variants, funct[1]=1 selects divide.
    logic        md_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    assign md_signed = ~funct[0];
    assign a_neg     = md_signed & in_Dato1[31];
    assign b_neg     = md_signed & op_b[31];
    assign a_mag     = a_neg ? (32'd0 - in_Dato1) : in_Dato1;
    assign b_mag     = b_neg ? (32'd0 - op_b) : op_b;

    logic [32:0] mul_sum, div_rem, div_diff;
    logic [63:0] prod;
    logic [31:0] quot, remd;
    assign mul_sum  = {1'b0, mhi_q} + (mlo_q[0] ? {1'b0, mb_q} : 33'd0);
    assign div_rem  = {mhi_q, mlo_q[31]};
    assign div_diff = div_rem - {1'b0, mb_q};
    assign prod     = negq_q ? (64'd0 - {mhi_q, mlo_q}) : {mhi_q, mlo_q};
    assign quot     = negq_q ? (32'd0 - mlo_q) : mlo_q;
    assign remd     = negr_q ? (32'd0 - mhi_q) : mhi_q;

    // The DONE cycle releases the stall so the held mul/div can retire into EX/MEM.
    assign ou_stall = (in_valid & is_md & (state_q != DONE)) | (state_q == BUSY);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mhi_d   = mhi_q;
        mlo_d   = mlo_q;
        mb_d    = mb_q;
        a_d     = a_q;
        div_d   = div_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (in_valid && is_md) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    mhi_d   = '0;
                    mlo_d   = a_mag;
                    mb_d    = b_mag;
                    a_d     = in_Dato1;
                    div_d   = funct[1];
                    negq_d  = a_neg ^ b_neg;
                    negr_d  = a_neg;
                end
            end
            BUSY: begin
                if (div_q) begin
                    // Restoring step: keep the trial subtraction only if it did not borrow.
                    if (!div_diff[32]) begin
                        mhi_d = div_diff[31:0];
                        mlo_d = {mlo_q[30:0], 1'b1};
                    end else begin
                        mhi_d = div_rem[31:0];
                        mlo_d = {mlo_q[30:0], 1'b0};
                    end
                end else begin
                    mhi_d = mul_sum[32:1];
                    mlo_d = {mul_sum[0], mlo_q[31:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MD_CYCLES - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!div_q) begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end else if (mb_q == 32'd0) begin
                    hi_d = a_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = remd;
                    lo_d = quot;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mhi_q   <= '0;
            mlo_q   <= '0;
            mb_q    <= '0;
            a_q     <= '0;
            div_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mhi_q   <= mhi_d;
            mlo_q   <= mlo_d;
            mb_q    <= mb_d;
            a_q     <= a_d;
            div_q   <= div_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        alu_res = '0;
        wr_en   = 1'b1;
        case (alu_op)
            3'b000: alu_res = in_Dato1 + op_b;
            3'b001: alu_res = in_Dato1 - op_b;
            3'b010: begin
                case (funct)
                    6'h20: alu_res = in_Dato1 + op_b;
                    6'h22: alu_res = in_Dato1 - op_b;
                    6'h24: alu_res = in_Dato1 & op_b;
                    6'h25: alu_res = in_Dato1 | op_b;
                    6'h27: alu_res = ~(in_Dato1 | op_b);
                    6'h2A: alu_res = {31'd0, $signed(in_Dato1) < $signed(op_b)};
                    6'h00: alu_res = op_b << in_Extend[10:6];
                    6'h10: alu_res = hi_q;
                    6'h12: alu_res = lo_q;
                    default: wr_en = 1'b0;
                endcase
            end
            3'b011: alu_res = in_Dato1 & op_b;
            3'b100: alu_res = in_Dato1 | op_b;
            3'b101: alu_res = {31'd0, $signed(in_Dato1) < $signed(op_b)};
            3'b110: alu_res = op_b << 16;
            default: alu_res = op_b;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ou_valid      <= 1'b0;
            ou_alu        <= '0;
            ou_zero       <= 1'b0;
            ou_branch_add <= '0;
            ou_Dato_2     <= '0;
            ou_wreg       <= '0;
        end else if (ou_stall || !in_valid) begin
            ou_valid      <= 1'b0;
            ou_alu        <= '0;
            ou_zero       <= 1'b0;
            ou_branch_add <= '0;
            ou_Dato_2     <= '0;
            ou_wreg       <= '0;
        end else begin
            ou_valid      <= 1'b1;
            ou_alu        <= alu_res;
            ou_zero       <= (alu_res == 32'd0);
            ou_branch_add <= in_add + {in_Extend[29:0], 2'b00};
            ou_Dato_2     <= in_Dato2;
            ou_wreg       <= wr_en ? dest : 5'd0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard testbench for ex_stage with a behavioural reference model
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [4:0]  in_EX;
    logic [31:0] in_add, in_Dato1, in_Dato2, in_Extend;
    logic [4:0]  in_b20_16, in_b15_11;
    logic        ou_stall, ou_valid, ou_zero;
    logic [31:0] ou_alu, ou_branch_add, ou_Dato_2;
    logic [4:0]  ou_wreg;

    ex_stage #(.MD_CYCLES(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_EX(in_EX),
        .in_add(in_add), .in_Dato1(in_Dato1), .in_Dato2(in_Dato2),
        .in_Extend(in_Extend), .in_b20_16(in_b20_16), .in_b15_11(in_b15_11),
        .ou_stall(ou_stall), .ou_valid(ou_valid), .ou_alu(ou_alu),
        .ou_zero(ou_zero), .ou_branch_add(ou_branch_add),
        .ou_Dato_2(ou_Dato_2), .ou_wreg(ou_wreg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic        zero;
        logic [31:0] br;
        logic [31:0] d2;
        logic [4:0]  wreg;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          passes = 0;
    bit          mon_en = 1'b0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    // Reference model: computes the EX/MEM result from the ISA rules and
    // updates the architectural HI/LO for mul/div.
    task automatic model(input logic [4:0] ex, input logic [31:0] pc4, a, d2, ext,
                         input logic [4:0] rt, rd, output exp_t e, output bit md);
        logic [31:0] b, r;
        logic [63:0] pu;
        longint      sa, sb, sp, sq, sr;
        bit          wr;
        b  = ex[1] ? ext : d2;
        r  = 32'd0;
        wr = 1'b1;
        md = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (ex[4:2])
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: begin
                case (ext[5:0])
                    6'h20: r = a + b;
                    6'h22: r = a - b;
                    6'h24: r = a & b;
                    6'h25: r = a | b;
                    6'h27: r = ~(a | b);
                    6'h2A: r = (sa < sb) ? 32'd1 : 32'd0;
                    6'h00: r = b << ext[10:6];
                    6'h10: r = hi_m;
                    6'h12: r = lo_m;
                    6'h18: begin
                        md = 1'b1; wr = 1'b0;
                        sp = sa * sb;
                        hi_m = sp[63:32]; lo_m = sp[31:0];
                    end
                    6'h19: begin
                        md = 1'b1; wr = 1'b0;
                        pu = {32'd0, a} * {32'd0, b};
                        hi_m = pu[63:32]; lo_m = pu[31:0];
                    end
                    6'h1A: begin
                        md = 1'b1; wr = 1'b0;
                        if (b == 32'd0) begin
                            hi_m = a; lo_m = 32'hFFFF_FFFF;
                        end else begin
                            sq = sa / sb; sr = sa % sb;
                            hi_m = sr[31:0]; lo_m = sq[31:0];
                        end
                    end
                    6'h1B: begin
                        md = 1'b1; wr = 1'b0;
                        if (b == 32'd0) begin
                            hi_m = a; lo_m = 32'hFFFF_FFFF;
                        end else begin
                            hi_m = a % b; lo_m = a / b;
                        end
                    end
                    default: wr = 1'b0;
                endcase
            end
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd6: r = b << 16;
            default: r = b;
        endcase
        e.alu  = r;
        e.zero = (r == 32'd0);
        e.br   = pc4 + (ext << 2);
        e.d2   = d2;
        e.wreg = wr ? (ex[0] ? rd : rt) : 5'd0;
    endtask

    // Present one instruction, hold it while stalled, queue its expected result.
    task automatic issue(input logic [4:0] ex, input logic [31:0] pc4, a, d2, ext,
                         input logic [4:0] rt, rd);
        exp_t e;
        bit   md;
        int   stalls;
        model(ex, pc4, a, d2, ext, rt, rd, e, md);
        in_EX = ex; in_add = pc4; in_Dato1 = a; in_Dato2 = d2; in_Extend = ext;
        in_b20_16 = rt; in_b15_11 = rd; in_valid = 1'b1;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!ou_stall) break;
            stalls++;
            if (stalls > 100) break;
        end
        check(md ? "stall_cycles_md" : "stall_cycles", 32'(stalls), md ? 32'd33 : 32'd0);
        sb_q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (ou_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("alu", ou_alu, e.alu);
                    check("zero", 32'(ou_zero), 32'(e.zero));
                    check("branch_add", ou_branch_add, e.br);
                    check("dato2", ou_Dato_2, e.d2);
                    check("wreg", 32'(ou_wreg), 32'(e.wreg));
                end
            end else begin
                check("bubble", ou_alu | ou_branch_add | ou_Dato_2 | 32'(ou_wreg) | 32'(ou_zero), 32'd0);
            end
        end
    end

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return 32'(0 - $urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    localparam int NF = 14;
    logic [5:0] functs [NF] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00,
                                6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h3F};

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_EX = '0; in_add = '0; in_Dato1 = '0;
        in_Dato2 = '0; in_Extend = '0; in_b20_16 = '0; in_b15_11 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(ou_valid), 32'd0);
        check("rst_alu", ou_alu, 32'd0);
        check("rst_wreg", 32'(ou_wreg), 32'd0);
        check("rst_stall", 32'(ou_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        issue(5'b01001, 32'h0, 32'h7FFF_FFFF, 32'd1, 32'h20, 5'd2, 5'd8);
        issue(5'b01001, 32'h0, 32'd5, 32'd5, 32'h22, 5'd2, 5'd9);
        issue(5'b00100, 32'h104, 32'd3, 32'd4, 32'hFFFF_FFFE, 5'd1, 5'd0);
        issue(5'b00010, 32'h40, 32'h1000, 32'h55, 32'hFFFF_FFFC, 5'd5, 5'd0);
        issue(5'b01001, 32'h0, 32'hFFFF_FFFD, 32'd7, 32'h18, 5'd0, 5'd0);
        issue(5'b01001, 32'h0, 32'd0, 32'd0, 32'h12, 5'd0, 5'd3);
        issue(5'b01001, 32'h0, 32'd0, 32'd0, 32'h10, 5'd0, 5'd4);
        issue(5'b01001, 32'h0, 32'hFFFF_FFFF, 32'd2, 32'h19, 5'd0, 5'd0);
        issue(5'b01001, 32'h0, 32'd0, 32'd0, 32'h10, 5'd0, 5'd3);
        issue(5'b01001, 32'h0, 32'd0, 32'd0, 32'h12, 5'd0, 5'd4);
        issue(5'b01001, 32'h0, 32'hFFFF_FFF9, 32'd2, 32'h1A, 5'd0, 5'd0);
        issue(5'b01001, 32'h0, 32'd0, 32'd0, 32'h12, 5'd0, 5'd3);
        issue(5'b01001, 32'h0, 32'd0, 32'd0, 32'h10, 5'd0, 5'd4);
        issue(5'b01001, 32'h0, 32'd9, 32'd0, 32'h1B, 5'd0, 5'd0);
        issue(5'b01001, 32'h0, 32'd0, 32'd0, 32'h10, 5'd0, 5'd3);
        issue(5'b01001, 32'h0, 32'd0, 32'd0, 32'h12, 5'd0, 5'd4);
        issue(5'b01001, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1A, 5'd0, 5'd0);
        issue(5'b01001, 32'h0, 32'd0, 32'd0, 32'h12, 5'd0, 5'd3);
        issue(5'b01001, 32'h0, 32'd0, 32'd0, 32'h10, 5'd0, 5'd4);
        issue(5'b01001, 32'h0, 32'd12, 32'd12, 32'h18, 5'd0, 5'd0);
        issue(5'b01001, 32'h0, 32'd1, 32'd2, 32'h20, 5'd0, 5'd6);

        // A mul/div presented with in_valid low must not start
        in_EX = 5'b01001; in_Extend = 32'h18; in_Dato1 = 32'd3; in_Dato2 = 32'd3;
        @(negedge clk);
        check("no_start_stall", 32'(ou_stall), 32'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of a multiply
        in_EX = 5'b01001; in_Extend = 32'h18; in_Dato1 = 32'd1234; in_Dato2 = 32'd77;
        in_valid = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_stall", 32'(ou_stall), 32'd0);
        check("midrst_valid", 32'(ou_valid), 32'd0);
        check("midrst_alu", ou_alu, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hi_m = 32'd0;
        lo_m = 32'd0;
        @(posedge clk);
        #1;
        issue(5'b01001, 32'h0, 32'd0, 32'd0, 32'h10, 5'd0, 5'd3);
        issue(5'b01001, 32'h0, 32'd0, 32'd0, 32'h12, 5'd0, 5'd4);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            logic [4:0]  ex;
            logic [31:0] ext;
            ex  = 5'($urandom);
            ext = rnd32();
            if ($urandom_range(0, 1) == 0) begin
                ex[4:2] = 3'b010;
                ext[5:0] = functs[$urandom_range(0, NF - 1)];
            end
            issue(ex, $urandom, rnd32(), rnd32(), ext, 5'($urandom), 5'($urandom));
            if ($urandom_range(0, 5) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b0;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline, directly downstream of the ID/EX buffer. Consumes decoded operands, extended immediate, PC+4, destination fields and the 5-bit EX control group. Computes the ALU result, branch target and write-register number, runs an iterative multiply/divide unit with HI/LO registers, and registers everything into the EX/MEM boundary. Stalls upstream stages while a multiply or divide is in progress.

## Interface
Parameters:
- MD_CYCLES, 32, iterations per multiply/divide (fixed at 32 for this design)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ID/EX holds a real instruction (0 = bubble)
- in_EX  in  5  [0] RegDst, [1] ALUSrc, [4:2] ALUOp
- in_add  in  32  PC+4
- in_Dato1  in  32  rs operand (A)
- in_Dato2  in  32  rt operand; also store data
- in_Extend  in  32  sign-extended immediate; [5:0] funct, [10:6] shamt
- in_b20_16  in  5  rt field
- in_b15_11  in  5  rd field
- ou_stall  out  1  hold PC, IF/ID and ID/EX this cycle
- ou_valid  out  1  EX/MEM holds a real instruction
- ou_alu  out  32  ALU result
- ou_zero  out  1  ALU result == 0
- ou_branch_add  out  32  branch target
- ou_Dato_2  out  32  store data (rt)
- ou_wreg  out  5  destination register; 0 = no write

## Operation
- B = ALUSrc ? in_Extend : in_Dato2. Destination = RegDst ? in_b15_11 : in_b20_16.
- ALUOp: 000 add, 001 sub, 010 R-type by funct, 011 and, 100 or, 101 slt (signed), 110 lui (B<<16), 111 pass B.
- Funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt, 0x00 sll (B<<shamt), 0x10 mfhi, 0x12 mflo, 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu; other funct → result 0, wreg 0.
- Add/sub wrap modulo 2^32; no overflow trap. Branch target = in_add + (in_Extend<<2), modulo 2^32.
- mult/div instructions write only HI/LO; their ou_wreg = 0.
- Mul/div FSM, states IDLE, BUSY, DONE:
  - IDLE: in_valid & muldiv op → latch |A|, |B|, sign info, op; cnt=0; → BUSY.
  - BUSY: one shift-add (mult) or restoring-subtract (div) step per edge; cnt++; at cnt==31 → DONE.
  - DONE: HI/LO written at the edge; → IDLE.
- Signed ops on magnitudes; product negated if signs differ; quotient sign = sign(A)^sign(B), remainder sign = sign(A). 0x80000000/-1: LO=0x80000000, HI=0.
- Divide by zero: HI=A, LO=0xFFFFFFFF; same duration.
- mult: HI = product[63:32], LO = product[31:0]. div: LO = quotient, HI = remainder.

## Timing
- Reset (asynchronous, rst_n=0): all outputs 0, HI=LO=0, FSM IDLE, cnt=0. Reset during BUSY aborts the operation; HI/LO read 0 afterwards.
- ou_stall (combinational) = (in_valid & muldiv & state!=DONE) | state==BUSY.
- Non-muldiv instruction: 1-cycle latency; EX/MEM outputs valid the edge after presentation.
- Muldiv presented in IDLE at cycle 0: stall high cycles 0..32, low in cycle 33 (DONE); HI/LO and EX/MEM (ou_valid=1, ou_wreg=0) update at end of cycle 33. 34 cycles in stage.
- Every edge with ou_stall=1 loads a bubble into EX/MEM (ou_valid=0, ou_wreg=0, other outputs 0).
- mfhi/mflo directly following a mult/div reads the new HI/LO (no extra hazard).
- in_valid=0 → EX/MEM bubble; FSM not started.

## Test plan
- Reset mid-BUSY: rst_n low at cycle 10 of a mult → all outputs 0, stall 0, later mfhi returns 0.
- R-type add: A=0x7FFFFFFF, B=1, RegDst=1, rd=8 → next edge ou_alu=0x80000000, ou_wreg=8, ou_zero=0; sub A=B=5 → ou_zero=1.
- beq-style: in_add=0x00000104, in_Extend=0xFFFFFFFE → ou_branch_add=0x000000FC; lw ALUSrc=1 A=0x1000, imm=0xFFFFFFFC → ou_alu=0x0FFC, wreg=rt.
- mult A=-3, B=7: stall high 33 cycles, then mflo → 0xFFFFFFEB, mfhi → 0xFFFFFFFF; multu 0xFFFFFFFF×2 → HI=1, LO=0xFFFFFFFE.
- div A=-7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu by 0 with A=9 → HI=9, LO=0xFFFFFFFF after 34 cycles.
- Back-to-back mult then add: add held on inputs until mult DONE, then completes next cycle; bubbles (ou_valid=0) appear during stall.
